// File: rtl/snake_draw_pkg.sv
// Shared definitions for the snake game drawing path.
// Holds the VGA screen geometry, coordinate/colour widths, the block
// drawing FSM state encoding and the on-screen clip test.
package snake_draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } draw_state_t;

    // Sums are one bit wider than the screen coordinates so that a block
    // hanging off the right/bottom edge is clipped instead of wrapping.
    function automatic logic on_screen(input logic [X_W:0] sum_x,
                                       input logic [Y_W:0] sum_y);
        return (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector, one bit per requester
//   ptr   : index of the highest-priority requester this round
//   grant : one-hot grant of the first set req bit at or after ptr,
//           wrapping modulo NREQ; all zero when no request is set
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    logic found;

    // First pass covers indices ptr..NREQ-1, second pass wraps to 0..ptr-1.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!found && req[j] && (j >= 32'(ptr))) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!found && req[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_draw_arbiter.sv
// Arbitrates between block draw requesters (head draw, tail erase, food
// draw) and rasterises the winner's square block into VGA pixel writes.
//   clk, reset     : clock, asynchronous active-high reset
//   req            : per-requester level request, held until ack
//   x_in/y_in/c_in : packed per-requester block top-left and colour
//   ack            : one-cycle one-hot pulse, request latched
//   done           : one-cycle one-hot pulse, block fully written
//   busy           : high whenever not idle
//   x_out/y_out/c_out/plot : pixel write port to the VGA adapter
module block_draw_arbiter
    import snake_draw_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int SIDE_LOG2 = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [X_W*NREQ-1:0] x_in,
    input  logic [Y_W*NREQ-1:0] y_in,
    input  logic [C_W*NREQ-1:0] c_in,
    output logic [NREQ-1:0]     ack,
    output logic [NREQ-1:0]     done,
    output logic                busy,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [C_W-1:0]      c_out,
    output logic                plot
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = 2 * SIDE_LOG2;

    draw_state_t        state;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   win_q;
    logic [NREQ-1:0]    gnt_q;
    logic [X_W-1:0]     base_x;
    logic [Y_W-1:0]     base_y;

    logic [NREQ-1:0]    grant;
    logic [PTR_W-1:0]   win_idx;
    logic [X_W-1:0]     win_x;
    logic [Y_W-1:0]     win_y;
    logic [C_W-1:0]     win_c;

    logic [X_W-1:0]     src_x;
    logic [Y_W-1:0]     src_y;
    logic [SIDE_LOG2-1:0] col;
    logic [SIDE_LOG2-1:0] row;
    logic [X_W:0]       sum_x;
    logic [Y_W:0]       sum_y;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        win_idx = '0;
        win_x   = '0;
        win_y   = '0;
        win_c   = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (grant[j]) begin
                win_idx = PTR_W'(j);
                win_x   = x_in[j*X_W +: X_W];
                win_y   = y_in[j*Y_W +: Y_W];
                win_c   = c_in[j*C_W +: C_W];
            end
        end
    end

    // Outputs are registered, so the adder computes the pixel for the
    // coming cycle: the winner's corner on grant, else base + next count.
    always_comb begin
        count_nxt = count + CNT_W'(1);
        if (state == IDLE) begin
            src_x = win_x;
            src_y = win_y;
            col   = '0;
            row   = '0;
        end else begin
            src_x = base_x;
            src_y = base_y;
            col   = count_nxt[SIDE_LOG2-1:0];
            row   = count_nxt[CNT_W-1:SIDE_LOG2];
        end
        sum_x = {1'b0, src_x} + (X_W+1)'(col);
        sum_y = {1'b0, src_y} + (Y_W+1)'(row);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            ptr    <= '0;
            win_q  <= '0;
            gnt_q  <= '0;
            base_x <= '0;
            base_y <= '0;
            ack    <= '0;
            done   <= '0;
            busy   <= 1'b0;
            plot   <= 1'b0;
            x_out  <= '0;
            y_out  <= '0;
            c_out  <= '0;
        end else begin
            ack  <= '0;
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state  <= DRAW;
                        busy   <= 1'b1;
                        count  <= '0;
                        win_q  <= win_idx;
                        gnt_q  <= grant;
                        base_x <= win_x;
                        base_y <= win_y;
                        ack    <= grant;
                        // c_out doubles as the latched colour for the block.
                        c_out  <= win_c;
                        x_out  <= sum_x[X_W-1:0];
                        y_out  <= sum_y[Y_W-1:0];
                        plot   <= on_screen(sum_x, sum_y);
                    end
                end
                DRAW: begin
                    if (count == '1) begin
                        state <= DONE;
                        count <= '0;
                        plot  <= 1'b0;
                        x_out <= '0;
                        y_out <= '0;
                        c_out <= '0;
                        done  <= gnt_q;
                        ptr   <= (win_q == PTR_W'(NREQ-1)) ? '0 : win_q + PTR_W'(1);
                    end else begin
                        count <= count_nxt;
                        x_out <= sum_x[X_W-1:0];
                        y_out <= sum_y[Y_W-1:0];
                        plot  <= on_screen(sum_x, sum_y);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_draw_arbiter.sv
// Directed self-checking bench for block_draw_arbiter (NREQ=3, 4x4 blocks).
module tb_block_draw_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [23:0] x_in;
    logic [20:0] y_in;
    logic [8:0]  c_in;
    logic [2:0]  ack;
    logic [2:0]  done;
    logic        busy;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  c_out;
    logic        plot;

    int errors = 0;
    int checks = 0;

    block_draw_arbiter #(
        .NREQ      (3),
        .SIDE_LOG2 (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .x_in  (x_in),
        .y_in  (y_in),
        .c_in  (c_in),
        .ack   (ack),
        .done  (done),
        .busy  (busy),
        .x_out (x_out),
        .y_out (y_out),
        .c_out (c_out),
        .plot  (plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_fields(input int i, input int x, input int y, input int c);
        x_in[i*8 +: 8] = 8'(x);
        y_in[i*7 +: 7] = 7'(y);
        c_in[i*3 +: 3] = 3'(c);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        checks++;
        if ({ack, done, busy, plot, x_out, y_out, c_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b done=%b busy=%b plot=%b x=%0d y=%0d c=%b expected all zero",
                     ack, done, busy, plot, x_out, y_out, c_out);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ack !== 3'b000) begin
            errors++;
            $display("FAIL idle_no_req: busy=%b ack=%b expected 0 and 000", busy, ack);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_fields(0, 10, 20, 3'b100);
        req = 3'b001;
        @(negedge clk);
        checks++;
        if (ack !== 3'b001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_ack: ack=%b busy=%b expected 001 and 1", ack, busy);
        end
        req[0] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            // inputs changing mid-block must not disturb the latched block
            if (k == 5) set_fields(0, 200, 100, 3'b001);
            checks++;
            if (plot !== 1'b1 || x_out !== 8'(10 + k % 4) || y_out !== 7'(20 + k / 4)
                || c_out !== 3'b100 || ack !== ((k == 0) ? 3'b001 : 3'b000) || done !== 3'b000) begin
                errors++;
                $display("FAIL single_pixel%0d: plot=%b x=%0d y=%0d c=%b ack=%b done=%b expected 1 %0d %0d 100 %b 000",
                         k, plot, x_out, y_out, c_out, ack, done, 10 + k % 4, 20 + k / 4,
                         (k == 0) ? 3'b001 : 3'b000);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 3'b001 || plot !== 1'b0 || busy !== 1'b1 || c_out !== 3'b000 || x_out !== 8'd0) begin
            errors++;
            $display("FAIL single_done: done=%b plot=%b busy=%b c=%b x=%0d expected 001 0 1 000 0",
                     done, plot, busy, c_out, x_out);
        end
        @(negedge clk);
        checks++;
        if (done !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: done=%b busy=%b expected 000 0", done, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp;
        int t;
        int plots;
        do_reset();
        set_fields(0, 0, 0, 1);
        set_fields(1, 40, 30, 2);
        set_fields(2, 80, 60, 5);
        req = 3'b111;
        for (int r = 0; r < 3; r++) begin
            exp = 3'b001 << r;
            t = 0;
            while (ack === 3'b000 && t < 50) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (ack !== exp || t != ((r == 0) ? 1 : 2)) begin
                errors++;
                $display("FAIL rr_grant%0d: ack=%b after %0d cycles expected %b after %0d",
                         r, ack, t, exp, (r == 0) ? 1 : 2);
            end
            req = req & ~ack;
            plots = 0;
            t = 0;
            while (done === 3'b000 && t < 50) begin
                if (plot === 1'b1) plots++;
                @(negedge clk);
                t++;
            end
            checks++;
            if (done !== exp || plots != 16 || t != 16) begin
                errors++;
                $display("FAIL rr_block%0d: done=%b plots=%0d cycles=%0d expected %b 16 16",
                         r, done, plots, t, exp);
            end
        end
        // pointer back at 0: requester 0 must beat requester 2
        req = 3'b101;
        t = 0;
        while (ack === 3'b000 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (ack !== 3'b001) begin
            errors++;
            $display("FAIL rr_ptr_wrap: ack=%b expected 001", ack);
        end
        req = '0;
    endtask

    task automatic test_fairness();
        int t;
        int wait2;
        do_reset();
        set_fields(1, 50, 50, 3);
        set_fields(2, 100, 100, 6);
        req = 3'b010;
        t = 0;
        while (ack === 3'b000 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (ack !== 3'b010) begin
            errors++;
            $display("FAIL fair_first: ack=%b expected 010", ack);
        end
        repeat (3) @(negedge clk);
        req[2] = 1'b1;
        wait2 = 0;
        t = 0;
        while (done === 3'b000 && t < 50) begin
            @(negedge clk);
            t++;
            wait2++;
        end
        checks++;
        if (done !== 3'b010) begin
            errors++;
            $display("FAIL fair_done1: done=%b expected 010", done);
        end
        t = 0;
        while (ack === 3'b000 && t < 50) begin
            @(negedge clk);
            t++;
            wait2++;
        end
        checks++;
        if (ack !== 3'b100 || wait2 > 20) begin
            errors++;
            $display("FAIL fair_second: ack=%b waited %0d expected 100 within 20", ack, wait2);
        end
        req[2] = 1'b0;
        t = 0;
        while (done === 3'b000 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done !== 3'b100) begin
            errors++;
            $display("FAIL fair_done2: done=%b expected 100", done);
        end
        t = 0;
        while (ack === 3'b000 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (ack !== 3'b010) begin
            errors++;
            $display("FAIL fair_third: ack=%b expected 010", ack);
        end
        req = '0;
    endtask

    task automatic test_clip();
        int t;
        logic exp_plot;
        int nplot;
        do_reset();
        set_fields(0, 158, 118, 7);
        req = 3'b001;
        @(negedge clk);
        req = '0;
        nplot = 0;
        for (int k = 0; k < 16; k++) begin
            exp_plot = (k % 4 < 2) && (k / 4 < 2);
            if (plot === 1'b1) nplot++;
            checks++;
            if (plot !== exp_plot || x_out !== 8'(158 + k % 4) || y_out !== 7'(118 + k / 4)
                || c_out !== 3'd7) begin
                errors++;
                $display("FAIL clip_pixel%0d: plot=%b x=%0d y=%0d c=%0d expected %b %0d %0d 7",
                         k, plot, x_out, y_out, c_out, exp_plot, 158 + k % 4, 118 + k / 4);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 3'b001 || nplot != 4) begin
            errors++;
            $display("FAIL clip_done: done=%b plots=%0d expected 001 4", done, nplot);
        end
        t = 0;
        while (busy === 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_reset_mid_draw();
        int t;
        logic saw_done;
        do_reset();
        set_fields(0, 30, 40, 2);
        set_fields(1, 60, 70, 5);
        req = 3'b001;
        @(negedge clk);
        req = '0;
        repeat (7) @(negedge clk);
        checks++;
        if (plot !== 1'b1 || x_out !== 8'd33 || y_out !== 7'd41 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_count7: plot=%b x=%0d y=%0d busy=%b expected 1 33 41 1",
                     plot, x_out, y_out, busy);
        end
        req   = 3'b110;
        reset = 1'b1;
        #1;
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || ack !== 3'b000 || done !== 3'b000
            || x_out !== 8'd0 || c_out !== 3'd0) begin
            errors++;
            $display("FAIL mid_async: plot=%b busy=%b ack=%b done=%b x=%0d c=%0d expected all zero",
                     plot, busy, ack, done, x_out, c_out);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        t = 0;
        while (ack === 3'b000 && t < 50) begin
            @(negedge clk);
            if (done !== 3'b000) saw_done = 1'b1;
            t++;
        end
        checks++;
        if (ack !== 3'b010 || saw_done !== 1'b0 || t != 1) begin
            errors++;
            $display("FAIL mid_regrant: ack=%b done_seen=%b latency=%0d expected 010 0 1",
                     ack, saw_done, t);
        end
        req = '0;
        t = 0;
        while (done === 3'b000 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done !== 3'b010) begin
            errors++;
            $display("FAIL mid_done: done=%b expected 010", done);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        x_in  = '0;
        y_in  = '0;
        c_in  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_clip();
        test_reset_mid_draw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
